adder_sequencer: RTL and testbench
==================================

ADDER_SEQUENCER -- requirements
Module: adder_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk input 1 (all state updates on rising edge), then reset input 1 (synchronous, active-high).
REQ-002 The block SHALL have these requester-0 ports: req0_valid input 1 (request present); req0_op input 2 (operation); req0_a input 32 (operand A); req0_b input 32 (operand B); req0_ready output 1 (request accepted this cycle).
REQ-003 The block SHALL have requester-1 ports req1_valid, req1_op, req1_a, req1_b, req1_ready, identical in width and meaning to requester 0.
REQ-004 The block SHALL have these result ports: out_valid output 1 (one-cycle result strobe); out_id output 1 (requester that owns the result); out_result output 32 (sum); out_z output 1 (result zero); out_n output 1 (result bit 31).

Function
REQ-005 Operation encoding SHALL be: 00 ADD (a+b), 01 SUB (a-b), 10 NEG (-a), 11 INC (a+1); all arithmetic SHALL be modulo 2^32, two's complement.
REQ-006 All additions SHALL use a single shared 32-bit adder with no carry-in; negation SHALL be formed as bitwise-invert then add 1.
REQ-007 The FSM SHALL use the states IDLE, PASS1, PASS2 and DONE.
REQ-008 In IDLE, ready SHALL be asserted combinationally to at most one requester with valid high, chosen by the round-robin pointer; a transfer SHALL occur when valid and ready are both high, with op, a and b captured at that edge and the next state set to PASS1.
REQ-009 In PASS1, the adder inputs SHALL be: ADD (a, b); SUB (~b, 1); NEG (~a, 1); INC (a, 1). The sum SHALL be registered, and the next state SHALL be PASS2 for SUB and DONE otherwise.
REQ-010 In PASS2 (SUB only), the adder inputs SHALL be (a, PASS1 sum), the sum SHALL be registered, and the next state SHALL be DONE.
REQ-011 In DONE, out_valid SHALL be 1 for exactly one cycle with registered out_result, out_id, out_z (result == 0) and out_n (result[31]); the next state SHALL be IDLE.
REQ-012 Latency from the accept edge to out_valid high SHALL be 2 cycles for ADD/NEG/INC and 3 cycles for SUB; there SHALL be no back-pressure on results.
REQ-013 Outside IDLE, both ready outputs SHALL be 0; requesters SHALL hold valid and operands until ready.
REQ-014 Round-robin: the pointer SHALL be 0 after reset; when only one requester is valid it SHALL win regardless of the pointer; after any grant to requester i, the pointer SHALL become 1-i.
REQ-015 When both requesters are valid, the requester selected by the pointer SHALL win, and the loser SHALL stay un-granted until the next IDLE cycle.
REQ-016 Outside DONE, out_result, out_id, out_z and out_n SHALL hold their last values; out_valid SHALL be 0.
REQ-017 Arithmetic edge cases SHALL wrap with no flag: NEG of 0x80000000 SHALL give 0x80000000 with N=1, and INC of 0xFFFFFFFF SHALL give 0 with Z=1.

Reset
REQ-018 On reset: state IDLE, pointer 0, out_valid 0, out_id 0, out_result 0, out_z 0, out_n 0, and internal operand/sum registers 0.
REQ-019 Reset during PASS1, PASS2 or DONE SHALL abort the operation, produce no out_valid for it, and leave ready low during the reset cycle.

Structure
REQ-020 Op codes (ADD/SUB/NEG/INC) and state encodings SHALL live in a shared package/include, adder_seq_pkg, for reuse by the decoder and testbench.
REQ-021 The block SHALL instantiate exactly one full_adder_32; its Z/N outputs MAY drive out_z/out_n via registers, or the flags MAY be recomputed from the registered sum.
REQ-022 The adder operand muxing, FSM, arbiter and result registers SHALL be in this module; no further sub-modules SHALL be added.

Verification
REQ-023 Scenario: req0 ADD a=5, b=7 alone -> ready0 in cycle 0; out_valid in cycle 2; result 12, id 0, Z=0, N=0.
REQ-024 Scenario: req1 SUB a=3, b=10 -> out_valid 3 cycles after accept; result 0xFFFFFFF9, N=1, id 1.
REQ-025 Scenario: both valid continuously with INC a=0 after reset -> grants alternate 0,1,0,1; first grant is req0; each result is 1.
REQ-026 Scenario: NEG a=0x80000000 -> result 0x80000000, N=1; INC a=0xFFFFFFFF -> result 0, Z=1; SUB a=b=0x1234 -> result 0, Z=1.
REQ-027 Scenario: reset asserted in PASS2 of a SUB -> no out_valid; state IDLE; pointer 0; next request accepted the cycle after reset deasserts.
REQ-028 Scenario: req0 valid held high during a busy period -> ready0 stays 0 until IDLE; operands are captured only at the handshake edge.

Source files
------------

// File: rtl/adder_seq_pkg.sv
// Shared op codes, FSM state encoding and datapath constants for the
// two-requester adder sequencer and anything that drives or checks it.
package adder_seq_pkg;

  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] ADD_ONE = {{(DATA_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_NEG = 2'b10,
    OP_INC = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PASS1 = 2'b01,
    PASS2 = 2'b10,
    DONE  = 2'b11
  } state_t;

endpackage

// File: rtl/full_adder_32.sv
// Plain 32-bit adder with no carry-in; zero and sign flags come from the sum.
module full_adder_32
  import adder_seq_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sum,
  output logic              z,
  output logic              n
);

  assign sum = a + b;
  assign z   = (sum == '0);
  assign n   = sum[DATA_W-1];

endmodule

// File: rtl/adder_sequencer.sv
// Two-requester arithmetic sequencer: one request at a time is run through a
// single shared adder in one (ADD/NEG/INC) or two (SUB) passes.
module adder_sequencer
  import adder_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [1:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [1:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              req1_ready,
  output logic              out_valid,
  output logic              out_id,
  output logic [DATA_W-1:0] out_result,
  output logic              out_z,
  output logic              out_n
);

  state_t            state;
  state_t            state_nxt;
  op_t               op_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] sum_q;
  logic              id_q;
  logic              rr_ptr;

  logic              grant0;
  logic              grant1;
  logic              accept;
  logic              load_out;
  op_t               sel_op;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;

  logic [DATA_W-1:0] add_x;
  logic [DATA_W-1:0] add_y;
  logic [DATA_W-1:0] add_sum;
  logic              add_z;
  logic              add_n;

  // Handshake: a request transfers on a rising edge where valid and ready are
  // both high. Ready is only offered in IDLE (never while reset is high), to at
  // most one requester; a requester holds valid and operands until it sees ready.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE && !reset) begin
      if (req0_valid && (!req1_valid || !rr_ptr)) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign accept     = grant0 | grant1;

  always_comb begin
    sel_op = grant1 ? op_t'(req1_op) : op_t'(req0_op);
    sel_a  = grant1 ? req1_a : req0_a;
    sel_b  = grant1 ? req1_b : req0_b;
  end

  // SUB runs as ~b+1 in PASS1, then a+(-b) in PASS2.
  always_comb begin
    add_x = '0;
    add_y = '0;
    case (state)
      PASS1: begin
        case (op_q)
          OP_ADD: begin
            add_x = a_q;
            add_y = b_q;
          end
          OP_SUB: begin
            add_x = ~b_q;
            add_y = ADD_ONE;
          end
          OP_NEG: begin
            add_x = ~a_q;
            add_y = ADD_ONE;
          end
          default: begin
            add_x = a_q;
            add_y = ADD_ONE;
          end
        endcase
      end
      PASS2: begin
        add_x = a_q;
        add_y = sum_q;
      end
      default: begin
        add_x = '0;
        add_y = '0;
      end
    endcase
  end

  full_adder_32 u_adder (
    .a   (add_x),
    .b   (add_y),
    .sum (add_sum),
    .z   (add_z),
    .n   (add_n)
  );

  always_comb begin
    state_nxt = state;
    load_out  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = PASS1;
        end
      end
      PASS1: begin
        if (op_q == OP_SUB) begin
          state_nxt = PASS2;
        end else begin
          state_nxt = DONE;
          load_out  = 1'b1;
        end
      end
      PASS2: begin
        state_nxt = DONE;
        load_out  = 1'b1;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Result registers load on the edge into DONE, so out_valid is high exactly
  // for the DONE cycle and the outputs hold afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q       <= OP_ADD;
      a_q        <= '0;
      b_q        <= '0;
      sum_q      <= '0;
      id_q       <= 1'b0;
      rr_ptr     <= 1'b0;
      out_valid  <= 1'b0;
      out_id     <= 1'b0;
      out_result <= '0;
      out_z      <= 1'b0;
      out_n      <= 1'b0;
    end else begin
      if (accept) begin
        op_q   <= sel_op;
        a_q    <= sel_a;
        b_q    <= sel_b;
        id_q   <= grant1;
        rr_ptr <= ~grant1;
      end
      if (state == PASS1 || state == PASS2) begin
        sum_q <= add_sum;
      end
      out_valid <= load_out;
      if (load_out) begin
        out_result <= add_sum;
        out_id     <= id_q;
        out_z      <= add_z;
        out_n      <= add_n;
      end
    end
  end

endmodule

// File: tb/tb_adder_sequencer.sv
// Bench for adder_sequencer: vector table, random ops against a behavioural
// model, and hand-written arbitration / busy / reset-abort sequences.
module tb_adder_sequencer;
  import adder_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0;
  logic [1:0]  req0_op = 2'b00;
  logic [31:0] req0_a = '0;
  logic [31:0] req0_b = '0;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [1:0]  req1_op = 2'b00;
  logic [31:0] req1_a = '0;
  logic [31:0] req1_b = '0;
  logic        req1_ready;
  logic        out_valid;
  logic        out_id;
  logic [31:0] out_result;
  logic        out_z;
  logic        out_n;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // expected entry: {id, z, n, result}
  logic [34:0] exp_q[$];
  int          acc_q[$];
  int          lat_q[$];
  logic [34:0] mon_e;
  int          mon_acc;
  int          mon_lat;
  logic [31:0] last_result = '0;

  typedef struct {
    int          port;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[12];

  adder_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_id     (out_id),
    .out_result (out_result),
    .out_z      (out_z),
    .out_n      (out_n)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return 32'd0 - a;
      default: return a + 32'd1;
    endcase
  endfunction

  function automatic logic rdy(input int port);
    return (port == 0) ? req0_ready : req1_ready;
  endfunction

  // driver tasks
  task automatic drive_req(input int port, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (port == 0) begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end
  endtask

  task automatic clear_reqs();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic push_exp(input int port, input logic [31:0] res, input int lat);
    logic id;
    id = (port != 0);
    exp_q.push_back({id, (res == 32'd0), res[31], res});
    acc_q.push_back(cyc);
    lat_q.push_back(lat);
  endtask

  task automatic do_op(input int port, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res);
    int waited;
    waited = 0;
    @(negedge clk);
    drive_req(port, op, a, b);
    #1;
    while (!rdy(port) && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    total++;
    if (!rdy(port)) begin
      bad++;
      $display("FAIL grant_timeout: port %0d got no ready in %0d cycles", port, waited);
      clear_reqs();
      return;
    end
    push_exp(port, exp_res, (op == 2'b01) ? 3 : 2);
    @(posedge clk);
    #1;
    clear_reqs();
  endtask

  task automatic wait_idle();
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
      exp_q.delete(); acc_q.delete(); lat_q.delete();
      return;
    end
    @(negedge clk);
    #1;
    check("hold_result", out_result, last_result);
    check("hold_valid", {31'd0, out_valid}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    clear_reqs();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    last_result = '0;
  endtask

  // scoreboard: compare every result strobe against the oldest expectation
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out_valid: got result %08h id %0d, expected no strobe", out_result, out_id);
      end else begin
        mon_e   = exp_q.pop_front();
        mon_acc = acc_q.pop_front();
        mon_lat = lat_q.pop_front();
        check("result", out_result, mon_e[31:0]);
        check("id", {31'd0, out_id}, {31'd0, mon_e[34]});
        check("z_flag", {31'd0, out_z}, {31'd0, mon_e[33]});
        check("n_flag", {31'd0, out_n}, {31'd0, mon_e[32]});
        check("latency", cyc - mon_acc, mon_lat);
        last_result = mon_e[31:0];
      end
    end
  end

  initial begin
    int order[4];
    int gcount;
    int port;
    logic [1:0] op;
    logic [31:0] a;
    logic [31:0] b;

    vecs[0]  = '{0, OP_ADD, 32'd5,        32'd7,        32'd12};
    vecs[1]  = '{1, OP_SUB, 32'd3,        32'd10,       32'hFFFF_FFF9};
    vecs[2]  = '{0, OP_NEG, 32'h8000_0000, 32'h55,      32'h8000_0000};
    vecs[3]  = '{1, OP_INC, 32'hFFFF_FFFF, 32'h77,      32'h0000_0000};
    vecs[4]  = '{0, OP_SUB, 32'h1234,      32'h1234,    32'h0000_0000};
    vecs[5]  = '{1, OP_ADD, 32'hFFFF_FFFF, 32'd1,       32'h0000_0000};
    vecs[6]  = '{0, OP_NEG, 32'd0,         32'd9,       32'h0000_0000};
    vecs[7]  = '{1, OP_NEG, 32'd1,         32'd0,       32'hFFFF_FFFF};
    vecs[8]  = '{0, OP_SUB, 32'd0,         32'd1,       32'hFFFF_FFFF};
    vecs[9]  = '{1, OP_ADD, 32'h7FFF_FFFF, 32'd1,       32'h8000_0000};
    vecs[10] = '{0, OP_INC, 32'h7FFF_FFFF, 32'hABCD,    32'h8000_0000};
    vecs[11] = '{1, OP_SUB, 32'h8000_0000, 32'd1,       32'h7FFF_FFFF};

    // reset state
    do_reset();
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_result", out_result, 32'd0);
    check("rst_out_id", {31'd0, out_id}, 32'd0);
    check("rst_out_z", {31'd0, out_z}, 32'd0);
    check("rst_out_n", {31'd0, out_n}, 32'd0);
    check("rst_ready0_idle", {31'd0, req0_ready}, 32'd0);
    check("rst_ready1_idle", {31'd0, req1_ready}, 32'd0);

    // vector table
    for (int i = 0; i < 12; i++) begin
      do_op(vecs[i].port, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
    end
    wait_idle();

    // random ops against the behavioural model
    for (int i = 0; i < 16; i++) begin
      port = $urandom_range(0, 1);
      op   = 2'($urandom_range(0, 3));
      a    = $urandom;
      b    = $urandom;
      do_op(port, op, a, b, model(op, a, b));
    end
    wait_idle();

    // both requesters valid continuously after reset: grants alternate 0,1,0,1
    do_reset();
    @(negedge clk);
    drive_req(0, OP_INC, 32'd0, 32'h11);
    drive_req(1, OP_INC, 32'd0, 32'h22);
    gcount = 0;
    for (int c = 0; c < 40 && gcount < 4; c++) begin
      #1;
      total++;
      if (req0_ready && req1_ready) begin
        bad++;
        $display("FAIL ready_exclusive: got both readies high, expected at most one");
      end else if (req0_ready || req1_ready) begin
        order[gcount] = req1_ready ? 1 : 0;
        push_exp(order[gcount], 32'd1, 2);
        gcount++;
      end
      if (gcount < 4) @(negedge clk);
    end
    @(posedge clk);
    #1;
    clear_reqs();
    check("rr_grant_count", gcount, 4);
    for (int i = 0; i < gcount; i++) begin
      check("rr_grant_order", order[i], i % 2);
    end
    wait_idle();

    // requester 0 waits through a busy period; operands taken at its handshake
    @(negedge clk);
    drive_req(1, OP_ADD, 32'd1, 32'd2);
    #1;
    check("busy_ready1_idle", {31'd0, req1_ready}, 32'd1);
    push_exp(1, 32'd3, 2);
    @(posedge clk);
    #1;
    req1_valid = 1'b0;
    drive_req(0, OP_ADD, 32'hDEAD, 32'd1);
    @(negedge clk);
    #1;
    check("busy_ready0_pass1", {31'd0, req0_ready}, 32'd0);
    check("busy_ready1_pass1", {31'd0, req1_ready}, 32'd0);
    req0_a = 32'd10;
    req0_b = 32'd20;
    @(negedge clk);
    #1;
    check("busy_ready0_done", {31'd0, req0_ready}, 32'd0);
    @(negedge clk);
    #1;
    check("busy_ready0_idle", {31'd0, req0_ready}, 32'd1);
    push_exp(0, 32'd30, 2);
    @(posedge clk);
    #1;
    clear_reqs();
    wait_idle();

    // reset during PASS2 of a SUB aborts it; pointer returns to 0
    do_reset();
    @(negedge clk);
    drive_req(0, OP_SUB, 32'd9, 32'd4);
    #1;
    check("abort_accept", {31'd0, req0_ready}, 32'd1);
    @(posedge clk);
    #1;
    clear_reqs();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    drive_req(0, OP_INC, 32'h40, 32'd0);
    drive_req(1, OP_INC, 32'h80, 32'd0);
    #1;
    check("abort_ready0_in_reset", {31'd0, req0_ready}, 32'd0);
    check("abort_ready1_in_reset", {31'd0, req1_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_no_valid", {31'd0, out_valid}, 32'd0);
    check("abort_out_result", out_result, 32'd0);
    check("abort_ready0_after", {31'd0, req0_ready}, 32'd1);
    check("abort_ready1_after", {31'd0, req1_ready}, 32'd0);
    if (req0_ready) push_exp(0, 32'h41, 2);
    @(posedge clk);
    #1;
    clear_reqs();
    last_result = '0;
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
